// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified instruction/data memory arbiter:
// FSM states, grant encoding and the saturating streak helper.
package unified_mem_arbiter_pkg;

  localparam int STREAK_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } gnt_t;

  function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v,
                                                  input logic [STREAK_W-1:0] lim);
    logic [STREAK_W-1:0] res;
    if (v >= lim) begin
      res = v;
    end else begin
      res = v + {{(STREAK_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Data-first arbitration with a fetch starvation guard: once MAX_D_STREAK data
// grants have gone by while a fetch waits, the next contended slot goes to fetch.
module mem_arb_grant
  import unified_mem_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_if_req,
  input  logic i_d_req,
  input  logic i_arb_en,
  output gnt_t o_gnt
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] r_streak;
  logic [STREAK_W-1:0] w_streak_nxt;
  gnt_t                w_gnt;

  always_comb begin
    w_gnt = GNT_NONE;
    if (!i_arb_en) begin
      w_gnt = GNT_NONE;
    end else if (i_d_req && (!i_if_req || (r_streak != STREAK_MAX))) begin
      w_gnt = GNT_D;
    end else if (i_if_req) begin
      w_gnt = GNT_I;
    end else begin
      w_gnt = GNT_NONE;
    end
  end

  // The streak only counts data wins that actually made a fetch wait.
  always_comb begin
    w_streak_nxt = r_streak;
    if (!i_arb_en) begin
      w_streak_nxt = r_streak;
    end else if ((w_gnt == GNT_I) || !i_if_req) begin
      w_streak_nxt = {STREAK_W{1'b0}};
    end else if (w_gnt == GNT_D) begin
      w_streak_nxt = sat_inc(r_streak, STREAK_MAX);
    end else begin
      w_streak_nxt = r_streak;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_streak <= {STREAK_W{1'b0}};
    end else begin
      r_streak <= w_streak_nxt;
    end
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory shared by IF fetch and MEM load/store: grants in IDLE,
// holds a registered request through variable latency, then pulses done once.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_t            r_state;
  state_t            w_state_nxt;
  gnt_t              w_gnt;
  logic              w_arb_en;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_if_done;
  logic              r_d_done;
  logic              w_unused_addr_lsbs;

  assign w_arb_en           = (r_state == IDLE);
  assign w_unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

  mem_arb_grant #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_grant (
    .i_clk   (CLK),
    .i_rst_n (RESET),
    .i_if_req(if_req),
    .i_d_req (d_req),
    .i_arb_en(w_arb_en),
    .o_gnt   (w_gnt)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        case (w_gnt)
          GNT_I:   w_state_nxt = BUSY_I;
          GNT_D:   w_state_nxt = BUSY_D;
          default: w_state_nxt = IDLE;
        endcase
      end
      BUSY_I: begin
        if (mem_ready) begin
          w_state_nxt = RESP_I;
        end else begin
          w_state_nxt = BUSY_I;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          w_state_nxt = RESP_D;
        end else begin
          w_state_nxt = BUSY_D;
        end
      end
      RESP_I:  w_state_nxt = IDLE;
      RESP_D:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The winner's request is latched once so later input changes cannot disturb the access.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= {DATA_W{1'b0}};
      r_if_rdata  <= {DATA_W{1'b0}};
      r_d_rdata   <= {DATA_W{1'b0}};
      r_if_done   <= 1'b0;
      r_d_done    <= 1'b0;
    end else begin
      r_if_done <= 1'b0;
      r_d_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          case (w_gnt)
            GNT_D: begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= d_we;
              r_mem_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
              r_mem_wdata <= d_wdata;
            end
            GNT_I: begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= {if_addr[ADDR_W-1:2], 2'b00};
              r_mem_wdata <= {DATA_W{1'b0}};
            end
            default: begin
              r_mem_req <= 1'b0;
            end
          endcase
        end
        BUSY_I: begin
          if (mem_ready) begin
            r_if_rdata <= mem_rdata;
            r_if_done  <= 1'b1;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            if (!r_mem_we) begin
              r_d_rdata <= mem_rdata;
            end
            r_d_done  <= 1'b1;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_done   = r_if_done;
  assign d_done    = r_d_done;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench: stimulus queues expected memory accesses and done results,
// a memory responder and a done monitor check them independently.
module tb_unified_mem_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
  } mem_t;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    int          cyc;
  } done_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        if_req, d_req, d_we, if_done, d_done;
  logic [31:0] if_addr, d_addr, d_wdata, if_rdata, d_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_t  mem_q[$];
  done_t done_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  bit    stray = 1'b0;
  bit    abort_ok = 1'b0;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_mem(input logic [31:0] a, input logic we, input logic [31:0] wd,
                          input int w, input logic [31:0] rd);
    mem_t m;
    m.addr = a; m.we = we; m.wdata = wd; m.waits = w; m.rdata = rd;
    mem_q.push_back(m);
  endtask

  task automatic push_done(input bit is_d, input logic [31:0] rd, input int c);
    done_t e;
    e.is_d = is_d; e.rdata = rd; e.cyc = c;
    done_q.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Waits for a done pulse, then moves into the following IDLE cycle.
  task automatic wait_done();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(if_done || d_done) && n < 50);
    if (!(if_done || d_done)) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done pulse in %0d cycles", n);
    end
    step();
  endtask

  // Memory model: serves queued accesses with programmed wait states.
  initial begin : responder
    mem_t cur;
    int   left;
    bit   active;
    active = 1'b0;
    left = 0;
    cur = '{addr: 32'h0, we: 1'b0, wdata: 32'h0, waits: 0, rdata: 32'h0};
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      step();
      mem_ready = stray;
      mem_rdata = 32'hBAD0_0000 ^ 32'(cyc);
      if (mem_req) begin
        if (!active) begin
          if (mem_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_access: got addr %h expected no access", mem_addr);
            cur = '{addr: 32'h0, we: 1'b0, wdata: 32'h0, waits: 0, rdata: 32'h0};
          end else begin
            cur = mem_q.pop_front();
          end
          left = cur.waits;
          active = 1'b1;
        end
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_we", {31'b0, mem_we}, {31'b0, cur.we});
        if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
        if (left == 0) begin
          mem_ready = 1'b1;
          mem_rdata = cur.rdata;
          active = 1'b0;
        end else begin
          left--;
        end
      end else begin
        if (active && !abort_ok) begin
          total++;
          bad++;
          $display("FAIL mem_req_dropped: got mem_req 0 expected 1");
        end
        active = 1'b0;
      end
    end
  end

  // Done monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    done_t e;
    if (if_done || d_done) begin
      chk("done_exclusive", {31'b0, if_done & d_done}, 32'h0);
      if (done_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got if_done=%b d_done=%b expected none", if_done, d_done);
      end else begin
        e = done_q.pop_front();
        chk("done_kind", {31'b0, d_done}, {31'b0, e.is_d});
        chk("done_rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
        if (e.cyc > 0) chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"},   {31'b0, mem_req}, 32'h0);
    chk({tag, "_mem_we"},    {31'b0, mem_we}, 32'h0);
    chk({tag, "_if_done"},   {31'b0, if_done}, 32'h0);
    chk({tag, "_d_done"},    {31'b0, d_done}, 32'h0);
    chk({tag, "_mem_addr"},  mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_if_rdata"},  if_rdata, 32'h0);
    chk({tag, "_d_rdata"},   d_rdata, 32'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int base;
    RESET = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    repeat (3) step();
    chk_all_zero("reset");
    RESET = 1'b1;
    step();

    // Fetch only, zero wait.
    push_mem(32'h0000_0010, 1'b0, 32'h0, 0, 32'h2008_0005);
    push_done(1'b0, 32'h2008_0005, cyc + 2);
    if_addr = 32'h0000_0010; if_req = 1'b1;
    wait_done();
    if_req = 1'b0;

    // Load with 5 wait states.
    push_mem(32'h0000_0200, 1'b0, 32'h0, 5, 32'hCAFE_0042);
    push_done(1'b1, 32'hCAFE_0042, cyc + 7);
    d_addr = 32'h0000_0202; d_we = 1'b0; d_req = 1'b1;
    wait_done();
    d_req = 1'b0;

    // Contention: store wins, fetch follows; store leaves d_rdata alone.
    push_mem(32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 0, 32'h5555_AAAA);
    push_mem(32'h0000_0014, 1'b0, 32'h0, 1, 32'h0000_0013);
    push_done(1'b1, 32'hCAFE_0042, cyc + 2);
    push_done(1'b0, 32'h0000_0013, cyc + 6);
    if_addr = 32'h0000_0014; if_req = 1'b1;
    d_addr = 32'h0000_0103; d_we = 1'b1; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
    wait_done();
    d_req = 1'b0; d_we = 1'b0;
    wait_done();
    if_req = 1'b0;

    // Starvation: two rounds of 4 data grants then 1 fetch.
    base = cyc;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        push_mem(32'h0000_0400, 1'b0, 32'h0, 0, 32'h4000_0000 + 32'(r * 4 + k));
        push_done(1'b1, 32'h4000_0000 + 32'(r * 4 + k), base + 2 + 3 * (r * 5 + k));
      end
      push_mem(32'h0000_0020, 1'b0, 32'h0, 0, 32'h2000_0000 + 32'(r));
      push_done(1'b0, 32'h2000_0000 + 32'(r), base + 2 + 3 * (r * 5 + 4));
    end
    d_addr = 32'h0000_0400; d_we = 1'b0; d_req = 1'b1;
    if_addr = 32'h0000_0020; if_req = 1'b1;
    for (int i = 0; i < 10; i++) wait_done();
    d_req = 1'b0; if_req = 1'b0;

    // Stray mem_ready while idle.
    stray = 1'b1;
    repeat (3) step();
    stray = 1'b0;
    chk("stray_mem_req", {31'b0, mem_req}, 32'h0);
    chk("stray_if_rdata", if_rdata, 32'h2000_0001);
    chk("stray_d_rdata", d_rdata, 32'h4000_0007);
    step();

    // Reset during BUSY_D abandons the access.
    abort_ok = 1'b1;
    push_mem(32'h0000_0300, 1'b0, 32'h0, 20, 32'h7777_7777);
    d_addr = 32'h0000_0300; d_we = 1'b0; d_req = 1'b1;
    step();
    step();
    chk("abort_busy_mem_req", {31'b0, mem_req}, 32'h1);
    RESET = 1'b0; d_req = 1'b0;
    step();
    chk_all_zero("abort");
    step();
    RESET = 1'b1;
    step();
    step();
    abort_ok = 1'b0;

    // Fresh fetch after reset.
    push_mem(32'h0000_0044, 1'b0, 32'h0, 0, 32'h1234_5678);
    push_done(1'b0, 32'h1234_5678, cyc + 2);
    if_addr = 32'h0000_0047; if_req = 1'b1;
    wait_done();
    if_req = 1'b0;

    repeat (3) step();
    chk("done_q_empty", 32'(done_q.size()), 32'h0);
    chk("mem_q_empty", 32'(mem_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
